hilo_sequencer: RTL
===================

# hilo_sequencer

Sequences the shared multiplier and divider units and the HI/LO register pair in the multicycle CPU datapath. The main control unit issues a single start pulse with an operation select. This block then launches exactly one unit and waits for its completion. It steers the HI/LO source muxes and loads both registers in the same cycle, and reports completion or a divide-by-zero exception. While busy, it signals the control unit to hold in its stall state.

## Interface
- TIMEOUT, 40: maximum WAIT cycles before the watchdog fires (2..255); used only when the watchdog is compiled in.

- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
- op_start  in  1  request pulse from the control unit; sampled only in IDLE.
- op_sel  in  1  0 = MULT, 1 = DIV; sampled together with op_start.
- mult_done  in  1  multiplier completion (MultDone).
- div_done  in  1  divider completion (DivDone).
- div_zero  in  1  divider divide-by-zero flag (Div0).
- mult_ctrl  out  1  one-cycle start pulse to the multiplier (MultCtrl).
- div_ctrl  out  1  one-cycle start pulse to the divider (DivCtrl).
- hilo_src_sel  out  1  HI and LO mux select; 0 = mult outputs, 1 = div outputs.
- high_load  out  1  HI register load enable.
- low_load  out  1  LO register load enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse, coincident with high_load/low_load.
- div0_exc  out  1  one-cycle pulse on divide-by-zero.
- timeout_err  out  1  one-cycle pulse when the watchdog expires.

## Operation
- The FSM has four states: IDLE, LAUNCH, WAIT and WRITE. All outputs are Moore-decoded from the state register and op_q.
- IDLE:
  - All outputs are 0.
  - If op_start=1, latch op_sel into op_q and go to LAUNCH. Otherwise stay in IDLE.
- LAUNCH:
  - Assert mult_ctrl when op_q=0, or div_ctrl when op_q=1, for exactly one cycle.
  - Clear the watchdog counter and go to WAIT.
- WAIT, evaluated in this priority order:
  - op_q=1 and div_zero=1: pulse div0_exc on the next cycle and return to IDLE. HI/LO are not loaded.
  - The selected unit's done is 1: go to WRITE.
  - Watchdog compiled in and counter = TIMEOUT-1: pulse timeout_err on the next cycle and return to IDLE. HI/LO are not loaded.
  - Otherwise increment the counter (8-bit, no wrap is possible given the TIMEOUT range) and stay in WAIT.
- Done from the unselected unit is ignored in all states.
- div_zero has priority over div_done when both arrive in the same cycle.
- WRITE:
  - high_load=1, low_load=1 and done=1 for one cycle.
  - Return to IDLE.
- hilo_src_sel equals op_q in LAUNCH, WAIT and WRITE, and is 0 in IDLE.
- div0_exc and timeout_err are registered pulses, asserted in the first IDLE cycle after WAIT.
- op_start while busy=1 is ignored: it is not queued and op_q does not change.

## Timing
- Reset values: state=IDLE, op_q=0, counter=0, and every output is 0.
- Reset asserted mid-operation:
  - Immediate return to IDLE.
  - Any pending HI/LO write is dropped.
  - No done or exception pulse is produced.
- Latency, with op_start sampled at edge 0:
  - LAUNCH occupies cycle 1 and WAIT begins in cycle 2.
  - If done is first seen high in WAIT cycle k, WRITE occupies cycle k+1 and IDLE resumes in cycle k+2.
  - Minimum latency from op_start to done is 3 cycles (done already high in the first WAIT cycle).
- Back-to-back requests: an op_start sampled in the first IDLE cycle after WRITE is accepted, giving one idle cycle between operations.
- busy rises in the cycle after the accepted op_start and falls in the first IDLE cycle.

## Configuration
- HILO_SEQ_TIMEOUT_EN defined:
  - The watchdog counter and the TIMEOUT comparison are built in.
  - timeout_err operates as specified above.
- HILO_SEQ_TIMEOUT_EN undefined:
  - No counter is synthesized and WAIT holds indefinitely until done or div_zero.
  - timeout_err is tied to 0.
  - The port list is unchanged.

## Test plan
- MULT: op_start=1, op_sel=0; mult_done rises 33 cycles after mult_ctrl.
  - Required: mult_ctrl high for exactly 1 cycle.
  - Required: in WRITE, high_load=low_load=done=1 with hilo_src_sel=0; busy=0 the cycle after.
- DIV: op_sel=1; div_done arrives after 32 cycles.
  - Required: a single div_ctrl pulse, then WRITE with hilo_src_sel=1; mult_ctrl never asserted.
- DIV by zero: div_zero=1 in the 3rd WAIT cycle.
  - Required: div0_exc is a 1-cycle pulse; high_load, low_load and done stay 0 throughout.
  - Repeat with div_zero and div_done high in the same cycle; required: same result.
- Busy rejection and back-to-back:
  - During WAIT, pulse op_start with op_sel flipped. Required: no extra ctrl pulse and hilo_src_sel unchanged.
  - After WRITE, an op_start in the first IDLE cycle. Required: LAUNCH on the next cycle.
- Timeout (HILO_SEQ_TIMEOUT_EN, TIMEOUT=40): mult_done never rises.
  - Required: timeout_err pulses after exactly 40 WAIT cycles, then IDLE with no HI/LO load.
  - Without the macro, required: busy stays high after 200 cycles.
- Reset: drive reset=0 asynchronously during WAIT, mid-cycle.
  - Required: all outputs go to 0 before the next clock edge; no done pulse after release; the next op_start completes normally.

Source files
------------

// File: rtl/hilo_sequencer_if.sv
// hilo_sequencer_if: control-unit, mul/div unit and HI/LO handshake bundle for hilo_sequencer.
interface hilo_sequencer_if;
    logic op_start;
    logic op_sel;
    logic mult_done;
    logic div_done;
    logic div_zero;
    logic mult_ctrl;
    logic div_ctrl;
    logic hilo_src_sel;
    logic high_load;
    logic low_load;
    logic busy;
    logic done;
    logic div0_exc;
    logic timeout_err;
    modport master (
        output op_start, op_sel, mult_done, div_done, div_zero,
        input  mult_ctrl, div_ctrl, hilo_src_sel, high_load, low_load, busy, done, div0_exc, timeout_err
    );
    modport slave (
        input  op_start, op_sel, mult_done, div_done, div_zero,
        output mult_ctrl, div_ctrl, hilo_src_sel, high_load, low_load, busy, done, div0_exc, timeout_err
    );
endinterface

// File: rtl/hilo_sequencer.sv
// hilo_sequencer: launches one mul/div op, waits for completion, loads HI/LO together.
// Define HILO_SEQ_TIMEOUT_EN to build the WAIT watchdog (TIMEOUT cycles).
module hilo_sequencer
`ifdef HILO_SEQ_TIMEOUT_EN
#(
    parameter int TIMEOUT = 40
)
`endif
(
    input logic        clk,
    input logic        reset,
    hilo_sequencer_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_WRITE} state_t;
    state_t state_q, state_d;
    logic op_q, op_d;
    logic div0_q, div0_d;
    logic tout_q, tout_d;
    logic cnt_hit;
    logic unit_done;

`ifdef HILO_SEQ_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    assign cnt_hit = cnt_q == 8'(TIMEOUT - 1);
    always_comb begin
        cnt_d = state_q == S_LAUNCH ? 8'd0 : state_q == S_WAIT ? cnt_q + 8'd1 : cnt_q;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= 8'd0;
        else cnt_q <= cnt_d;
    end
`else
    assign cnt_hit = 1'b0;
`endif

    // only the launched unit's completion counts
    assign unit_done = op_q ? bus.div_done : bus.mult_done;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        div0_d  = 1'b0;
        tout_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.op_start) begin
                    op_d    = bus.op_sel;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT: begin
                if (op_q && bus.div_zero) begin
                    div0_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (unit_done) begin
                    state_d = S_WRITE;
                end else if (cnt_hit) begin
                    tout_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= 1'b0;
            div0_q  <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            div0_q  <= div0_d;
            tout_q  <= tout_d;
        end
    end

    assign bus.busy         = state_q != S_IDLE;
    assign bus.mult_ctrl    = state_q == S_LAUNCH && !op_q;
    assign bus.div_ctrl     = state_q == S_LAUNCH && op_q;
    assign bus.hilo_src_sel = bus.busy && op_q;
    assign bus.high_load    = state_q == S_WRITE;
    assign bus.low_load     = state_q == S_WRITE;
    assign bus.done         = state_q == S_WRITE;
    assign bus.div0_exc     = div0_q;
    assign bus.timeout_err  = tout_q;
endmodule
